// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: control-field indices,
// access-size encodings and the stage FSM state type.
package mem_access_stage_pkg;

    // Bit positions inside i_mem
    localparam int MEMREAD_BIT  = 4;
    localparam int MEMWRITE_BIT = 3;
    localparam int UNSIGNED_BIT = 2;
    localparam int SIZE_LSB     = 0;

    // Bit positions inside i_wb
    localparam int REGWRITE_BIT = 1;
    localparam int MEMTOREG_BIT = 0;

    // Access size encodings; 2'b10 decodes as a word
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/mem_access_stage_align.sv
// Combinational byte-lane logic for the MEM stage.
// Request side: byte enables, lane-replicated store data, misalignment.
// Response side: picks the addressed lane out of the read word and extends it.
module load_store_align
    import mem_access_stage_pkg::*;
(
    input  logic [1:0]  i_req_lane,
    input  logic [1:0]  i_req_size,
    input  logic [31:0] i_req_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata,
    output logic        o_misaligned,
    input  logic [1:0]  i_ld_lane,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_unsigned,
    input  logic [31:0] i_rdata,
    output logic [31:0] o_ldata
);

    // Store-side lane steering and alignment check
    always_comb begin
        o_be         = 4'b1111;
        o_wdata      = i_req_data;
        o_misaligned = 1'b0;
        case (i_req_size)
            SIZE_BYTE: begin
                o_be    = 4'b0001 << i_req_lane;
                o_wdata = {4{i_req_data[7:0]}};
            end
            SIZE_HALF: begin
                o_be         = i_req_lane[1] ? 4'b1100 : 4'b0011;
                o_wdata      = {2{i_req_data[15:0]}};
                o_misaligned = i_req_lane[0];
            end
            default: begin
                o_be         = 4'b1111;
                o_misaligned = |i_req_lane;
            end
        endcase
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sign;

    // Load-side lane extraction followed by sign/zero extension
    always_comb begin
        ld_byte = i_rdata[{i_ld_lane, 3'b000} +: 8];
        ld_half = i_ld_lane[1] ? i_rdata[31:16] : i_rdata[15:0];
        ld_sign = 1'b0;
        o_ldata = i_rdata;
        case (i_ld_size)
            SIZE_BYTE: begin
                ld_sign = ~i_ld_unsigned & ld_byte[7];
                o_ldata = {{24{ld_sign}}, ld_byte};
            end
            SIZE_HALF: begin
                ld_sign = ~i_ld_unsigned & ld_half[15];
                o_ldata = {{16{ld_sign}}, ld_half};
            end
            default: o_ldata = i_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory loads/stores over a req/ack bus,
// stalls upstream while an access is outstanding, and registers MEM/WB.
// Optional bus watchdog: define MEM_ACCESS_TIMEOUT_EN to add the TIMEOUT
// counter and the o_bus_error output.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_aluresult,
    input  logic [DATA_WIDTH-1:0] i_regB,
    input  logic [REG_ADDR-1:0]   i_rd_rt,
    input  logic [4:0]            i_mem,
    input  logic [1:0]            i_wb,
    output logic                  o_stall,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [DATA_WIDTH-3:0] o_dmem_addr,
    output logic [3:0]            o_dmem_be,
    output logic [DATA_WIDTH-1:0] o_dmem_wdata,
    input  logic                  i_dmem_ack,
    input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_readdata,
    output logic [DATA_WIDTH-1:0] o_aluresult,
    output logic [REG_ADDR-1:0]   o_rd_rt,
    output logic [1:0]            o_wb,
    output logic                  o_misaligned
`ifdef MEM_ACCESS_TIMEOUT_EN
    ,output logic                 o_bus_error
`endif
);

    // The lane logic is hard-wired for a 32-bit word
    if (DATA_WIDTH != 32) begin : g_bad_width
        $error("mem_access_stage: DATA_WIDTH must be 32");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("mem_access_stage: TIMEOUT must be at least 1");
    end

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  uns_q, uns_d;
    logic [1:0]            size_q, size_d;
    logic [REG_ADDR-1:0]   rd_q, rd_d;
    logic [1:0]            wb_q, wb_d;

    logic                  valid_q, valid_d;
    logic [DATA_WIDTH-1:0] readdata_q, readdata_d;
    logic [DATA_WIDTH-1:0] alu_q, alu_d;
    logic [REG_ADDR-1:0]   rd_out_q, rd_out_d;
    logic [1:0]            wb_out_q, wb_out_d;
    logic                  mis_q, mis_d;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  berr_q, berr_d;
`endif

    logic                  is_mem;
    logic [3:0]            req_be;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  req_mis;
    logic [DATA_WIDTH-1:0] ld_data;

    load_store_align u_align (
        .i_req_lane    (i_aluresult[1:0]),
        .i_req_size    (i_mem[SIZE_LSB +: 2]),
        .i_req_data    (i_regB),
        .o_be          (req_be),
        .o_wdata       (req_wdata),
        .o_misaligned  (req_mis),
        .i_ld_lane     (addr_q[1:0]),
        .i_ld_size     (size_q),
        .i_ld_unsigned (uns_q),
        .i_rdata       (i_dmem_rdata),
        .o_ldata       (ld_data)
    );

    assign is_mem = i_mem[MEMREAD_BIT] | i_mem[MEMWRITE_BIT];

    // Next-state and MEM/WB result selection; result regs only move on a pulse
    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        uns_d      = uns_q;
        size_d     = size_q;
        rd_d       = rd_q;
        wb_d       = wb_q;
        valid_d    = 1'b0;
        readdata_d = readdata_q;
        alu_d      = alu_q;
        rd_out_d   = rd_out_q;
        wb_out_d   = wb_out_q;
        mis_d      = mis_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
        cnt_d      = cnt_q;
        berr_d     = berr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (is_mem && !req_mis) begin
                        // Aligned access: latch the request, memread+memwrite is a store
                        state_d = ST_WAIT;
                        we_d    = i_mem[MEMWRITE_BIT];
                        addr_d  = i_aluresult;
                        be_d    = req_be;
                        wdata_d = req_wdata;
                        uns_d   = i_mem[UNSIGNED_BIT];
                        size_d  = i_mem[SIZE_LSB +: 2];
                        rd_d    = i_rd_rt;
                        wb_d    = i_wb;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end else begin
                        // Pass-through op, or a misaligned access faulted without a bus cycle
                        valid_d    = 1'b1;
                        readdata_d = '0;
                        alu_d      = i_aluresult;
                        rd_out_d   = i_rd_rt;
                        wb_out_d   = i_wb;
                        mis_d      = is_mem;
                        if (is_mem) wb_out_d[REGWRITE_BIT] = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                        berr_d     = 1'b0;
`endif
                    end
                end
            end
            ST_WAIT: begin
                if (i_dmem_ack) begin
                    state_d    = ST_IDLE;
                    valid_d    = 1'b1;
                    readdata_d = we_q ? '0 : ld_data;
                    alu_d      = addr_q;
                    rd_out_d   = rd_q;
                    wb_out_d   = wb_q;
                    mis_d      = 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
                    berr_d     = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    // Watchdog expired on this cycle: abandon the access
                    state_d    = ST_IDLE;
                    valid_d    = 1'b1;
                    readdata_d = '0;
                    alu_d      = addr_q;
                    rd_out_d   = rd_q;
                    wb_out_d   = wb_q;
                    wb_out_d[REGWRITE_BIT] = 1'b0;
                    mis_d      = 1'b0;
                    berr_d     = 1'b1;
                end else begin
                    cnt_d      = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pipeline registers; reset aborts any outstanding access
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            uns_q      <= 1'b0;
            size_q     <= '0;
            rd_q       <= '0;
            wb_q       <= '0;
            valid_q    <= 1'b0;
            readdata_q <= '0;
            alu_q      <= '0;
            rd_out_q   <= '0;
            wb_out_q   <= '0;
            mis_q      <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q      <= '0;
            berr_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            uns_q      <= uns_d;
            size_q     <= size_d;
            rd_q       <= rd_d;
            wb_q       <= wb_d;
            valid_q    <= valid_d;
            readdata_q <= readdata_d;
            alu_q      <= alu_d;
            rd_out_q   <= rd_out_d;
            wb_out_q   <= wb_out_d;
            mis_q      <= mis_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q      <= cnt_d;
            berr_q     <= berr_d;
`endif
        end
    end

    // Bus outputs come straight from registered state; gated so reset clears them
    assign o_stall      = (state_q == ST_WAIT);
    assign o_dmem_req   = (state_q == ST_WAIT);
    assign o_dmem_we    = o_dmem_req & we_q;
    assign o_dmem_addr  = o_dmem_req ? addr_q[DATA_WIDTH-1:2] : '0;
    assign o_dmem_be    = o_dmem_req ? be_q : '0;
    assign o_dmem_wdata = o_dmem_req ? wdata_q : '0;

    assign o_valid      = valid_q;
    assign o_readdata   = readdata_q;
    assign o_aluresult  = alu_q;
    assign o_rd_rt      = rd_out_q;
    assign o_wb         = wb_out_q;
    assign o_misaligned = mis_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    assign o_bus_error  = berr_q;
`endif

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus a
// randomized op stream checked against a byte-level reference model.
module tb_mem_access_stage;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_valid;
    logic [31:0] i_aluresult;
    logic [31:0] i_regB;
    logic [4:0]  i_rd_rt;
    logic [4:0]  i_mem;
    logic [1:0]  i_wb;
    logic        o_stall;
    logic        o_dmem_req;
    logic        o_dmem_we;
    logic [29:0] o_dmem_addr;
    logic [3:0]  o_dmem_be;
    logic [31:0] o_dmem_wdata;
    logic        i_dmem_ack;
    logic [31:0] i_dmem_rdata;
    logic        o_valid;
    logic [31:0] o_readdata;
    logic [31:0] o_aluresult;
    logic [4:0]  o_rd_rt;
    logic [1:0]  o_wb;
    logic        o_misaligned;
`ifdef MEM_ACCESS_TIMEOUT_EN
    logic        o_bus_error;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 i_clk = ~i_clk;

    mem_access_stage #(.DATA_WIDTH(32), .REG_ADDR(5), .TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid),
        .i_aluresult(i_aluresult), .i_regB(i_regB), .i_rd_rt(i_rd_rt),
        .i_mem(i_mem), .i_wb(i_wb), .o_stall(o_stall),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_be(o_dmem_be), .o_dmem_wdata(o_dmem_wdata),
        .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_valid(o_valid), .o_readdata(o_readdata), .o_aluresult(o_aluresult),
        .o_rd_rt(o_rd_rt), .o_wb(o_wb), .o_misaligned(o_misaligned)
`ifdef MEM_ACCESS_TIMEOUT_EN
        , .o_bus_error(o_bus_error)
`endif
    );

    // What one op looked like from outside the DUT
    typedef struct packed {
        bit          saw_req;
        bit          stable;
        int          stall_cycles;
        logic        we;
        logic [29:0] daddr;
        logic [3:0]  be;
        logic [31:0] wdata;
        bit          valid_seen;
        bit          valid_again;
        logic [31:0] rdata_o;
        logic [31:0] alu_o;
        logic [4:0]  rd_o;
        logic [1:0]  wb_o;
        logic        mis_o;
        logic        berr_o;
    } obs_t;

    // Reference expectations derived from byte-level rules
    typedef struct packed {
        bit          req;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        mis;
        logic [31:0] rdata;
        logic [1:0]  wb;
    } exp_t;

    function automatic exp_t model(input logic [31:0] addr, input logic [31:0] regb,
                                   input logic [4:0] mem, input logic [1:0] wb,
                                   input logic [31:0] rdata);
        exp_t e;
        int nbytes, off;
        logic [31:0] v;
        bit is_mem;
        e      = '0;
        is_mem = mem[4] | mem[3];
        nbytes = (mem[1:0] == 2'b00) ? 1 : (mem[1:0] == 2'b01) ? 2 : 4;
        off    = int'(addr % 4);
        e.mis  = is_mem && ((addr % nbytes) != 0);
        e.req  = is_mem && !e.mis;
        e.we   = mem[3];
        e.wb   = e.mis ? (wb & 2'b01) : wb;
        e.be   = 4'(((1 << nbytes) - 1) << off);
        for (int i = 0; i < 4; i++) e.wdata[8*i +: 8] = regb[8*(i % nbytes) +: 8];
        if (e.req && !mem[3]) begin
            v = rdata >> (8 * off);
            if (nbytes < 4) begin
                v = v & ((32'd1 << (8 * nbytes)) - 1);
                if (!mem[2] && v[8*nbytes-1]) v = v | ~((32'd1 << (8 * nbytes)) - 1);
            end
            e.rdata = v;
        end
        return e;
    endfunction

    // Presents one op, services the bus after n_wait WAIT cycles (0 = never ack)
    task automatic run_op(input logic [31:0] addr, input logic [31:0] regb,
                          input logic [4:0] mem, input logic [1:0] wb, input logic [4:0] rd,
                          input int n_wait, input logic [31:0] rdata, output obs_t o);
        int waits;
        o = '0;
        o.stable = 1'b1;
        waits = 0;
        i_valid = 1'b1; i_aluresult = addr; i_regB = regb; i_mem = mem; i_wb = wb; i_rd_rt = rd;
        @(negedge i_clk);
        i_valid = 1'b0; i_aluresult = $urandom; i_regB = $urandom; i_mem = 5'($urandom);
        i_wb = 2'($urandom); i_rd_rt = 5'($urandom);
        for (int c = 0; c < 64 && !o.valid_seen; c++) begin
            i_dmem_ack = 1'b0;
            i_dmem_rdata = $urandom;
            if (o_stall) o.stall_cycles++;
            if (o_valid) begin
                o.valid_seen = 1'b1;
                o.rdata_o = o_readdata; o.alu_o = o_aluresult; o.rd_o = o_rd_rt;
                o.wb_o = o_wb; o.mis_o = o_misaligned;
`ifdef MEM_ACCESS_TIMEOUT_EN
                o.berr_o = o_bus_error;
`endif
            end else begin
                if (o_dmem_req) begin
                    if (!o.saw_req) begin
                        o.saw_req = 1'b1;
                        o.we = o_dmem_we; o.daddr = o_dmem_addr; o.be = o_dmem_be; o.wdata = o_dmem_wdata;
                    end else if (o.we !== o_dmem_we || o.daddr !== o_dmem_addr ||
                                 o.be !== o_dmem_be || o.wdata !== o_dmem_wdata) begin
                        o.stable = 1'b0;
                    end
                    waits++;
                    if (waits == n_wait) begin
                        i_dmem_ack = 1'b1;
                        i_dmem_rdata = rdata;
                    end
                end
                @(negedge i_clk);
            end
        end
        i_dmem_ack = 1'b0;
        @(negedge i_clk);
        o.valid_again = o_valid;
    endtask

    task automatic test_reset();
        i_reset = 1'b0; i_valid = 1'b0; i_aluresult = '0; i_regB = '0; i_rd_rt = '0;
        i_mem = '0; i_wb = '0; i_dmem_ack = 1'b0; i_dmem_rdata = '0;
        #12;
        n_cmp++;
        if ({o_stall, o_dmem_req, o_dmem_we, o_dmem_addr, o_dmem_be, o_dmem_wdata,
             o_valid, o_readdata, o_aluresult, o_rd_rt, o_wb, o_misaligned} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs: some output nonzero, req=%b stall=%b valid=%b alu=%h want all 0",
                     o_dmem_req, o_stall, o_valid, o_aluresult);
        end
        @(negedge i_clk);
        i_reset = 1'b1;
        @(negedge i_clk);
    endtask

    task automatic test_alu_op();
        obs_t o;
        run_op(32'h0000_0040, 32'hDEAD_BEEF, 5'b00000, 2'b10, 5'd7, 1, 32'h0, o);
        n_cmp++; if (o.valid_seen !== 1'b1) begin n_err++; $display("FAIL alu_valid: got %b want 1", o.valid_seen); end
        n_cmp++; if (o.alu_o !== 32'h40) begin n_err++; $display("FAIL alu_result: got %h want 00000040", o.alu_o); end
        n_cmp++; if ({o.saw_req, o.stall_cycles} !== {1'b0, 32'd0}) begin n_err++; $display("FAIL alu_nostall: req=%b stall=%0d want 0/0", o.saw_req, o.stall_cycles); end
        n_cmp++; if ({o.rdata_o, o.rd_o, o.wb_o, o.mis_o} !== {32'h0, 5'd7, 2'b10, 1'b0}) begin n_err++; $display("FAIL alu_fields: rdata=%h rd=%0d wb=%b mis=%b want 0/7/10/0", o.rdata_o, o.rd_o, o.wb_o, o.mis_o); end
        n_cmp++; if (o.valid_again !== 1'b0) begin n_err++; $display("FAIL alu_pulse: valid still %b want 0", o.valid_again); end
    endtask

    task automatic test_byte_load();
        obs_t o;
        run_op(32'h0000_0103, 32'h0, 5'b10000, 2'b11, 5'd3, 3, 32'h80AA_BBCC, o);
        n_cmp++; if (o.be !== 4'b1000) begin n_err++; $display("FAIL lb_be: got %b want 1000", o.be); end
        n_cmp++; if (o.stall_cycles !== 3) begin n_err++; $display("FAIL lb_stall: got %0d want 3", o.stall_cycles); end
        n_cmp++; if (o.rdata_o !== 32'hFFFF_FF80) begin n_err++; $display("FAIL lb_signed: got %h want ffffff80", o.rdata_o); end
        n_cmp++; if ({o.we, o.daddr} !== {1'b0, 30'h40}) begin n_err++; $display("FAIL lb_bus: we=%b addr=%h want 0/40", o.we, o.daddr); end
        run_op(32'h0000_0103, 32'h0, 5'b10100, 2'b11, 5'd3, 3, 32'h80AA_BBCC, o);
        n_cmp++; if (o.rdata_o !== 32'h0000_0080) begin n_err++; $display("FAIL lbu_unsigned: got %h want 00000080", o.rdata_o); end
    endtask

    task automatic test_half_store();
        obs_t o;
        run_op(32'h0000_0106, 32'h1234_5678, 5'b01001, 2'b00, 5'd0, 1, 32'hFFFF_FFFF, o);
        n_cmp++; if ({o.we, o.be} !== {1'b1, 4'b1100}) begin n_err++; $display("FAIL sh_we_be: got %b/%b want 1/1100", o.we, o.be); end
        n_cmp++; if (o.wdata !== 32'h5678_5678) begin n_err++; $display("FAIL sh_wdata: got %h want 56785678", o.wdata); end
        n_cmp++; if (o.daddr !== 30'h41) begin n_err++; $display("FAIL sh_addr: got %h want 41", o.daddr); end
        n_cmp++; if (o.rdata_o !== 32'h0) begin n_err++; $display("FAIL sh_readdata: got %h want 0", o.rdata_o); end
        n_cmp++; if (o.stall_cycles !== 1) begin n_err++; $display("FAIL sh_min_latency: stall %0d want 1", o.stall_cycles); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        run_op(32'h0000_0102, 32'h0, 5'b10011, 2'b11, 5'd9, 1, 32'h0, o);
        n_cmp++; if (o.saw_req !== 1'b0) begin n_err++; $display("FAIL mis_noreq: req seen %b want 0", o.saw_req); end
        n_cmp++; if ({o.valid_seen, o.mis_o, o.wb_o} !== {1'b1, 1'b1, 2'b01}) begin n_err++; $display("FAIL mis_flags: valid=%b mis=%b wb=%b want 1/1/01", o.valid_seen, o.mis_o, o.wb_o); end
    endtask

    task automatic test_ack_in_idle();
        int bad;
        bad = 0;
        i_dmem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            if (o_valid || o_dmem_req || o_stall) bad++;
        end
        i_dmem_ack = 1'b0;
        n_cmp++; if (bad !== 0) begin n_err++; $display("FAIL idle_ack: %0d cycles with activity want 0", bad); end
    endtask

    task automatic test_reset_in_wait();
        obs_t o;
        int seen;
        seen = 0;
        i_valid = 1'b1; i_aluresult = 32'h200; i_mem = 5'b10011; i_wb = 2'b11; i_rd_rt = 5'd4;
        @(negedge i_clk);
        i_valid = 1'b0;
        @(negedge i_clk);
        #2 i_reset = 1'b0;
        #1;
        n_cmp++; if ({o_dmem_req, o_stall} !== 2'b00) begin n_err++; $display("FAIL rst_wait_async: req=%b stall=%b want 0/0", o_dmem_req, o_stall); end
        @(negedge i_clk);
        i_reset = 1'b1;
        i_dmem_ack = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            i_dmem_ack = 1'b0;
            if (o_valid || o_dmem_req) seen++;
        end
        n_cmp++; if (seen !== 0) begin n_err++; $display("FAIL rst_wait_novalid: %0d active cycles want 0", seen); end
        run_op(32'h0000_0055, 32'h0, 5'b00000, 2'b10, 5'd1, 1, 32'h0, o);
        n_cmp++; if ({o.valid_seen, o.alu_o} !== {1'b1, 32'h55}) begin n_err++; $display("FAIL rst_wait_idle: valid=%b alu=%h want 1/55", o.valid_seen, o.alu_o); end
    endtask

    task automatic test_random_stream();
        obs_t o;
        exp_t e;
        logic [31:0] addr, regb, rdata;
        logic [4:0]  mem, rd;
        logic [1:0]  wb;
        int nw;
        for (int k = 0; k < 60; k++) begin
            addr = $urandom; regb = $urandom; rdata = $urandom;
            mem = 5'($urandom); wb = 2'($urandom); rd = 5'($urandom);
            if (k % 5 == 0) mem[4:3] = 2'b00;
            nw = $urandom_range(1, 4);
            e = model(addr, regb, mem, wb, rdata);
            run_op(addr, regb, mem, wb, rd, nw, rdata, o);
            n_cmp++;
            if (o.saw_req !== e.req || o.valid_seen !== 1'b1 || o.valid_again !== 1'b0) begin
                n_err++; $display("FAIL rnd_handshake[%0d]: req=%b valid=%b again=%b want %b/1/0", k, o.saw_req, o.valid_seen, o.valid_again, e.req);
            end
            if (e.req) begin
                n_cmp++;
                if (o.be !== e.be || o.we !== e.we || o.daddr !== addr[31:2] || o.stable !== 1'b1 || o.stall_cycles !== nw ||
                    (e.we && o.wdata !== e.wdata)) begin
                    n_err++; $display("FAIL rnd_bus[%0d]: be=%b we=%b addr=%h wd=%h st=%b stall=%0d want %b/%b/%h/%h/1/%0d",
                                      k, o.be, o.we, o.daddr, o.wdata, o.stable, o.stall_cycles, e.be, e.we, addr[31:2], e.wdata, nw);
                end
            end
            n_cmp++;
            if (o.rdata_o !== e.rdata || o.mis_o !== e.mis || o.wb_o !== e.wb || o.alu_o !== addr || o.rd_o !== rd) begin
                n_err++; $display("FAIL rnd_result[%0d]: rdata=%h mis=%b wb=%b alu=%h rd=%0d want %h/%b/%b/%h/%0d",
                                  k, o.rdata_o, o.mis_o, o.wb_o, o.alu_o, o.rd_o, e.rdata, e.mis, e.wb, addr, rd);
            end
        end
    endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
    task automatic test_timeout();
        obs_t o;
        run_op(32'h0000_0300, 32'h0, 5'b10011, 2'b11, 5'd2, 0, 32'h0, o);
        n_cmp++; if ({o.valid_seen, o.berr_o, o.wb_o[1], o.stall_cycles} !== {1'b1, 1'b1, 1'b0, 32'd4}) begin
            n_err++; $display("FAIL timeout_abort: valid=%b berr=%b rw=%b stall=%0d want 1/1/0/4", o.valid_seen, o.berr_o, o.wb_o[1], o.stall_cycles);
        end
        run_op(32'h0000_0300, 32'h0, 5'b10011, 2'b11, 5'd2, 4, 32'hCAFE_F00D, o);
        n_cmp++; if ({o.berr_o, o.wb_o[1], o.rdata_o} !== {1'b0, 1'b1, 32'hCAFE_F00D}) begin
            n_err++; $display("FAIL timeout_ack_wins: berr=%b rw=%b rdata=%h want 0/1/cafef00d", o.berr_o, o.wb_o[1], o.rdata_o);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_op();
        test_byte_load();
        test_half_store();
        test_misaligned();
        test_ack_in_idle();
        test_reset_in_wait();
        test_random_stream();
`ifdef MEM_ACCESS_TIMEOUT_EN
        test_timeout();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
